sh_sync_param: RTL
==================

SH_SYNC_PARAM -- requirements
Module: sh_sync_param

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64: shift-buffer and frame length in bits (8..128).
REQ-002 SHALL have parameter BIT_CYCLES, default 10000: clk cycles per RF bit period (100 ns clk, 1 ms bit).
REQ-003 SHALL have parameter SYNC_MASK [FRAME_LEN-1:0], default bits 62:58, 36:32, 8:0 set: positions compared.
REQ-004 SHALL have parameter SYNC_PATTERN [FRAME_LEN-1:0], default all ones: expected value at masked positions.
REQ-005 SHALL have parameter MAX_ERR, default 0: maximum masked-bit mismatches still accepted as sync.
REQ-006 SHALL have parameter MISS_LIMIT, default 16: consecutive pulse-free bit windows that abort tracking.
REQ-007 SHALL have parameter PULSE_MODE, default 0: 0 = sh_en level until tx_rdy; 1 = sh_en one-cycle pulse.
REQ-008 clk  input  1  single clock; all state updates on its rising edge.
REQ-009 rst  input  1  synchronous, active-low reset.
REQ-010 rfin  input  1  asynchronous RF detector pulse, min width 1 clk.
REQ-011 RX  input  1  receive enable; low forces IDLE.
REQ-012 tx_rdy  input  1  downstream accepts the locked frame.
REQ-013 sh_en  output  1  sync found / frame valid.
REQ-014 frame_data  output  FRAME_LEN  frozen shift-buffer contents while sh_en asserted, MSB = oldest bit.
REQ-015 state  output  2  FSM state (IDLE=0, HUNT=1, TRACK=2, LOCKED=3).

Function
REQ-016 rfin SHALL pass a 2-flop synchronizer; rise = sync2 & ~sync3 (2-3 clk input latency).
REQ-017 IDLE: outputs quiet; RX=1 -> HUNT next cycle.
REQ-018 HUNT: first rise -> TRACK, win_cnt:=0, pulse_seen:=1, shreg:=0, bits_rx:=0, miss_cnt:=0.
REQ-019 TRACK: win_cnt counts 0..BIT_CYCLES-1 and wraps; any rise in window sets pulse_seen.
REQ-020 At win_cnt=BIT_CYCLES-1: shreg:={shreg[FRAME_LEN-2:0],pulse_seen}, pulse_seen:=0 (rise on that same cycle counts for the closing window), bits_rx increments saturating at FRAME_LEN.
REQ-021 miss_cnt SHALL increment on each window closed with pulse_seen=0, clear on pulse_seen=1; reaching MISS_LIMIT -> HUNT, shreg cleared.
REQ-022 Match evaluated on the next-shreg value at each window close only once bits_rx (post-increment) = FRAME_LEN: popcount((next_shreg ^ SYNC_PATTERN) & SYNC_MASK) <= MAX_ERR.
REQ-023 On match: shreg loads, frame_data:=next_shreg, sh_en:=1, state:=LOCKED on the same edge.
REQ-024 LOCKED, PULSE_MODE=0: sh_en held high, frame_data frozen until a cycle with tx_rdy=1; next edge sh_en:=0, state:=HUNT if RX=1 else IDLE.
REQ-025 LOCKED, PULSE_MODE=1: sh_en high exactly one cycle; frame_data held until tx_rdy=1; then as REQ-024.
REQ-026 tx_rdy=1 on the cycle sh_en first rises SHALL be honoured (sh_en high exactly 1 cycle).
REQ-027 RX=0 in HUNT/TRACK: next edge IDLE, shreg/counters cleared, sh_en stays 0; in LOCKED the frame is kept until tx_rdy.
REQ-028 Popcount/mismatch width SHALL be $clog2(FRAME_LEN+1); win_cnt width $clog2(BIT_CYCLES).

Reset
REQ-029 rst=0 at a clk edge: state=IDLE, sh_en=0, frame_data=0, shreg=0, all counters 0, synchronizer flops 0; dominates all inputs.
REQ-030 Reset mid-TRACK or mid-LOCKED SHALL discard the frame; no sh_en after release until a full new frame matches.

Verification (FRAME_LEN=16, BIT_CYCLES=8, SYNC_MASK=16'hF800, SYNC_PATTERN=16'hF800, MAX_ERR=0, MISS_LIMIT=4, unless noted)
REQ-031 RX=1, bits 11111 then 11 zeros (one pulse per window) -> sh_en rises at close of 16th window, frame_data=16'hF800, state=3.
REQ-032 Same with bit 13 = 0 -> no sh_en; rerun MAX_ERR=1 -> sh_en, frame_data=16'hD800.
REQ-033 PULSE_MODE=0, tx_rdy=0 for 20 cycles then 1 -> sh_en high 21 cycles, drops next edge, state=1.
REQ-034 PULSE_MODE=1 -> sh_en high 1 cycle; frame_data stable until tx_rdy.
REQ-035 4 empty windows in TRACK -> state=1, shreg=0; RX=0 mid-TRACK -> state=0 next edge.
REQ-036 rst=0 in LOCKED -> sh_en=0, frame_data=0, state=0 next edge.

Source files
------------

// File: rtl/sh_sync_param.sv
// RF pulse-position frame synchronizer: detector pulses are binned into fixed bit
// windows, shifted into a frame buffer and matched against a masked sync word.
module sh_sync_param #(
   parameter int                   FRAME_LEN    = 64,
   parameter int                   BIT_CYCLES   = 10000,
   parameter logic [FRAME_LEN-1:0] SYNC_MASK    = FRAME_LEN'(64'h7C00_001F_0000_01FF),
   parameter logic [FRAME_LEN-1:0] SYNC_PATTERN = {FRAME_LEN{1'b1}},
   parameter int                   MAX_ERR      = 0,
   parameter int                   MISS_LIMIT   = 16,
   parameter int                   PULSE_MODE   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rfin,
   input  logic                 RX,
   input  logic                 tx_rdy,
   output logic                 sh_en,
   output logic [FRAME_LEN-1:0] frame_data,
   output logic [1:0]           state
);

   localparam int PCW = $clog2(FRAME_LEN + 1);
   localparam int WCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int MCW = $clog2(MISS_LIMIT + 1);

   localparam logic [WCW-1:0] WIN_LAST   = WCW'(BIT_CYCLES - 1);
   localparam logic [PCW-1:0] FRAME_FULL = PCW'(FRAME_LEN);
   localparam logic [PCW-1:0] ERR_MAX    = PCW'((MAX_ERR > FRAME_LEN) ? FRAME_LEN : MAX_ERR);
   localparam logic [MCW-1:0] MISS_MAX   = MCW'(MISS_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_TRACK  = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q, sync3_q;
   logic [WCW-1:0]       win_cnt_q, win_cnt_d;
   logic                 pulse_seen_q, pulse_seen_d;
   logic [FRAME_LEN-1:0] shreg_q, shreg_d;
   logic [PCW-1:0]       bits_rx_q, bits_rx_d;
   logic [MCW-1:0]       miss_cnt_q, miss_cnt_d;
   logic                 sh_en_q, sh_en_d;
   logic [FRAME_LEN-1:0] frame_data_q, frame_data_d;

   logic                 rise;
   logic                 win_close;
   logic                 bit_in;
   logic [FRAME_LEN-1:0] shreg_shift;
   logic [PCW-1:0]       bits_rx_inc;
   logic [MCW-1:0]       miss_inc;
   logic [FRAME_LEN-1:0] mis_vec;
   logic [PCW-1:0]       mis_cnt;
   logic                 sync_match;
   logic                 clr_trk;

   assign rise        = sync2_q & ~sync3_q;
   assign win_close   = (win_cnt_q == WIN_LAST);
   // A rise on the closing cycle still belongs to the window being closed.
   assign bit_in      = pulse_seen_q | rise;
   assign shreg_shift = {shreg_q[FRAME_LEN-2:0], bit_in};
   assign bits_rx_inc = (bits_rx_q == FRAME_FULL) ? bits_rx_q : bits_rx_q + PCW'(1);
   assign miss_inc    = miss_cnt_q + MCW'(1);

   genvar gi;
   generate
      for (gi = 0; gi < FRAME_LEN; gi++) begin : g_mis
         assign mis_vec[gi] = (shreg_shift[gi] ^ SYNC_PATTERN[gi]) & SYNC_MASK[gi];
      end
   endgenerate

   always_comb begin
      mis_cnt = '0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         mis_cnt = mis_cnt + PCW'(mis_vec[i]);
      end
   end

   assign sync_match = (bits_rx_inc == FRAME_FULL) && (mis_cnt <= ERR_MAX);

   always_comb begin
      state_d      = state_q;
      win_cnt_d    = win_cnt_q;
      pulse_seen_d = pulse_seen_q;
      shreg_d      = shreg_q;
      bits_rx_d    = bits_rx_q;
      miss_cnt_d   = miss_cnt_q;
      sh_en_d      = sh_en_q;
      frame_data_d = frame_data_q;
      clr_trk      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sh_en_d      = 1'b0;
            frame_data_d = '0;
            clr_trk      = 1'b1;
            if (RX) begin
               state_d = ST_HUNT;
            end
         end

         ST_HUNT: begin
            clr_trk = 1'b1;
            if (!RX) begin
               state_d = ST_IDLE;
            end else if (rise) begin
               state_d = ST_TRACK;
            end
         end

         ST_TRACK: begin
            if (!RX) begin
               state_d = ST_IDLE;
               clr_trk = 1'b1;
            end else begin
               win_cnt_d    = win_close ? '0 : win_cnt_q + WCW'(1);
               pulse_seen_d = pulse_seen_q | rise;
               if (win_close) begin
                  pulse_seen_d = 1'b0;
                  shreg_d      = shreg_shift;
                  bits_rx_d    = bits_rx_inc;
                  miss_cnt_d   = bit_in ? '0 : miss_inc;
                  // A completed match wins over a simultaneous miss abort.
                  if (sync_match) begin
                     state_d      = ST_LOCKED;
                     frame_data_d = shreg_shift;
                     sh_en_d      = 1'b1;
                  end else if (!bit_in && (miss_inc == MISS_MAX)) begin
                     state_d = ST_HUNT;
                     clr_trk = 1'b1;
                  end
               end
            end
         end

         ST_LOCKED: begin
            if (PULSE_MODE != 0) begin
               sh_en_d = 1'b0;
            end
            if (tx_rdy) begin
               sh_en_d      = 1'b0;
               frame_data_d = '0;
               clr_trk      = 1'b1;
               state_d      = RX ? ST_HUNT : ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            clr_trk = 1'b1;
         end
      endcase

      // Every entry into TRACK starts a fresh frame with the entering pulse as bit one.
      if (clr_trk) begin
         win_cnt_d    = '0;
         pulse_seen_d = 1'b1;
         shreg_d      = '0;
         bits_rx_d    = '0;
         miss_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sync3_q      <= 1'b0;
         win_cnt_q    <= '0;
         pulse_seen_q <= 1'b0;
         shreg_q      <= '0;
         bits_rx_q    <= '0;
         miss_cnt_q   <= '0;
         sh_en_q      <= 1'b0;
         frame_data_q <= '0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= rfin;
         sync2_q      <= sync1_q;
         sync3_q      <= sync2_q;
         win_cnt_q    <= win_cnt_d;
         pulse_seen_q <= pulse_seen_d;
         shreg_q      <= shreg_d;
         bits_rx_q    <= bits_rx_d;
         miss_cnt_q   <= miss_cnt_d;
         sh_en_q      <= sh_en_d;
         frame_data_q <= frame_data_d;
      end
   end

   assign sh_en      = sh_en_q;
   assign frame_data = frame_data_q;
   assign state      = state_q;

endmodule
